led_blink_controller: RTL and testbench



---
 rtl/led_blink_controller_if.sv | 13 +
 rtl/led_blink_controller.sv | 91 +++++++++
 tb/tb_led_blink_controller.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/led_blink_controller_if.sv
// led_blink_controller_if: mode/config handshake between control logic and the LED blinker
interface led_blink_controller_if #(
    parameter int CNT_W = 24,
    parameter int BURST_W = 8
);
    logic valid;
    logic ready;
    logic [1:0] mode;
    logic [CNT_W-1:0] half_period;
    logic [BURST_W-1:0] count;
    modport master (output valid, mode, half_period, count, input ready);
    modport slave (input valid, mode, half_period, count, output ready);
endinterface

// File: rtl/led_blink_controller.sv
// led_blink_controller: off/on/blink/burst LED sequencer with reconfiguration deferred to half-period boundaries
module led_blink_controller #(
    parameter int CNT_W = 24,
    parameter int DEFAULT_HALF = 1000,
    parameter int BURST_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    led_blink_controller_if.slave cfg,
    output logic led,
    output logic tick,
    output logic busy,
    output logic done
);
    typedef enum logic [1:0] {OFF, ON, BLINK, BURST} mode_t;
    mode_t mode, mode_n, pmode, pmode_n, a_mode;
    logic [CNT_W-1:0] cnt, cnt_n, half, half_n, phalf, phalf_n, a_half;
    logic [BURST_W-1:0] rem, rem_n, pcount, pcount_n, a_count;
    logic pend, pend_n, led_n, done_n, running, accept, apply;
    assign running = mode == BLINK || mode == BURST;
    assign tick = running && cnt == half - CNT_W'(1);
    assign busy = mode == BURST;
    assign cfg.ready = !pend;
    assign accept = cfg.valid && !pend;
    // a pending config only exists while cfg_ready is low, so it never collides with a fresh accept
    assign apply = (tick && pend) || (accept && (!running || tick));
    assign a_mode = pend ? pmode : mode_t'(cfg.mode);
    assign a_half = pend ? phalf : cfg.half_period;
    assign a_count = pend ? pcount : cfg.count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= OFF;
            led <= 1'b0;
            cnt <= '0;
            half <= CNT_W'(DEFAULT_HALF);
            rem <= '0;
            pend <= 1'b0;
            pmode <= OFF;
            phalf <= '0;
            pcount <= '0;
            done <= 1'b0;
        end else begin
            mode <= mode_n;
            led <= led_n;
            cnt <= cnt_n;
            half <= half_n;
            rem <= rem_n;
            pend <= pend_n;
            pmode <= pmode_n;
            phalf <= phalf_n;
            pcount <= pcount_n;
            done <= done_n;
        end
    end
    always_comb begin
        mode_n = mode;
        led_n = led;
        cnt_n = running ? (tick ? '0 : cnt + CNT_W'(1)) : '0;
        half_n = half;
        rem_n = rem;
        pend_n = pend;
        pmode_n = pmode;
        phalf_n = phalf;
        pcount_n = pcount;
        done_n = 1'b0;
        if (apply) begin
            cnt_n = '0;
            half_n = a_half == '0 ? CNT_W'(1) : a_half;
            rem_n = a_count;
            pend_n = 1'b0;
            mode_n = (a_mode == BURST && a_count == '0) ? OFF : a_mode;
            led_n = a_mode == ON || a_mode == BLINK || (a_mode == BURST && a_count != '0);
            done_n = a_mode == BURST && a_count == '0;
        end else if (accept) begin
            pend_n = 1'b1;
            pmode_n = mode_t'(cfg.mode);
            phalf_n = cfg.half_period;
            pcount_n = cfg.count;
        end else if (tick) begin
            if (mode == BLINK || led) begin
                led_n = !led;
            end else begin
                // end of a burst off-half: one blink cycle consumed
                rem_n = rem == '0 ? '0 : rem - BURST_W'(1);
                mode_n = rem <= BURST_W'(1) ? OFF : mode;
                led_n = rem > BURST_W'(1);
                done_n = rem <= BURST_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_led_blink_controller.sv
// tb_led_blink_controller: scoreboard bench, expected {led,tick,busy,done,ready} per cycle queued then compared
module tb_led_blink_controller;
    typedef logic [4:0] obs_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic led, tick, busy, done;
    int total = 0;
    int bad = 0;
    obs_t sb[$];
    obs_t got, e;
    led_blink_controller_if #(.CNT_W(24), .BURST_W(8)) cif ();
    led_blink_controller #(.CNT_W(24), .DEFAULT_HALF(1000), .BURST_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg(cif), .led(led), .tick(tick), .busy(busy), .done(done)
    );
    assign got = {led, tick, busy, done, cif.ready};
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] m, input int h, input int c);
        cif.valid = 1'b1;
        cif.mode = m;
        cif.half_period = 24'(h);
        cif.count = 8'(c);
        @(posedge clk);
        #1;
        cif.valid = 1'b0;
    endtask

    task automatic do_reset();
        cif.valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 10; k++) sb.push_back(5'b00001);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step();
            e = sb.pop_front();
            total++;
            if (got !== e) begin bad++; $display("FAIL reset_idle k=%0d got=%b exp=%b", k, got, e); end
        end
        send(2'd2, 3, 0);
        step();
        @(negedge clk) rst_n = 1'b0;
        #1;
        total++;
        if (got !== 5'b00001) begin bad++; $display("FAIL async_reset got=%b exp=%b", got, 5'b00001); end
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    task automatic test_blink();
        do_reset();
        for (int k = 0; k < 18; k++) sb.push_back({k % 6 < 3, k % 3 == 2, 1'b0, 1'b0, 1'b1});
        send(2'd2, 3, 0);
        for (int k = 0; k < 18; k++) begin
            if (k > 0) step();
            e = sb.pop_front();
            total++;
            if (got !== e) begin bad++; $display("FAIL blink k=%0d got=%b exp=%b", k, got, e); end
        end
    endtask

    task automatic test_burst();
        do_reset();
        for (int k = 0; k < 12; k++) sb.push_back({k % 4 < 2, k % 2 == 1, 1'b1, 1'b0, 1'b1});
        sb.push_back(5'b00011);
        sb.push_back(5'b00001);
        sb.push_back(5'b00001);
        send(2'd3, 2, 3);
        for (int k = 0; k < 15; k++) begin
            if (k > 0) step();
            e = sb.pop_front();
            total++;
            if (got !== e) begin bad++; $display("FAIL burst k=%0d got=%b exp=%b", k, got, e); end
        end
    endtask

    task automatic test_deferred();
        do_reset();
        for (int k = 0; k < 1006; k++)
            sb.push_back(k < 11 ? 5'b10001 : k < 1000 ? {1'b1, k == 999, 3'b000} : 5'b10001);
        send(2'd2, 1000, 0);
        for (int k = 0; k < 1006; k++) begin
            if (k == 11) send(2'd1, 5, 0);
            else if (k > 0) step();
            e = sb.pop_front();
            total++;
            if (got !== e) begin bad++; $display("FAIL deferred k=%0d got=%b exp=%b", k, got, e); end
        end
    endtask

    task automatic test_half_zero();
        do_reset();
        for (int k = 0; k < 8; k++) sb.push_back({k % 2 == 0, 1'b1, 1'b0, 1'b0, 1'b1});
        sb.push_back(5'b00011);
        sb.push_back(5'b00001);
        send(2'd2, 0, 0);
        for (int k = 0; k < 10; k++) begin
            if (k == 8) send(2'd3, 4, 0);
            else if (k > 0) step();
            e = sb.pop_front();
            total++;
            if (got !== e) begin bad++; $display("FAIL half_zero k=%0d got=%b exp=%b", k, got, e); end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int k = 0; k < 10; k++) sb.push_back({k % 8 < 4, k % 4 == 3, 1'b1, 1'b0, 1'b1});
        send(2'd3, 4, 5);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step();
            e = sb.pop_front();
            total++;
            if (got !== e) begin bad++; $display("FAIL burst_pre_reset k=%0d got=%b exp=%b", k, got, e); end
        end
        @(negedge clk) rst_n = 1'b0;
        #1;
        total++;
        if (got !== 5'b00001) begin bad++; $display("FAIL burst_abort got=%b exp=%b", got, 5'b00001); end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 48; k++) sb.push_back({k % 4 < 2, k % 2 == 1, 1'b0, 1'b0, 1'b1});
        send(2'd2, 2, 0);
        for (int k = 0; k < 48; k++) begin
            if (k > 0) step();
            e = sb.pop_front();
            total++;
            if (got !== e) begin bad++; $display("FAIL post_abort k=%0d got=%b exp=%b", k, got, e); end
        end
    endtask

    initial begin
        cif.valid = 1'b0;
        cif.mode = 2'd0;
        cif.half_period = '0;
        cif.count = '0;
        test_reset();
        test_blink();
        test_burst();
        test_deferred();
        test_half_zero();
        test_reset_mid_burst();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
